// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared state encoding, inst bus field map and status bit indices for core_seq
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_RD,
        S_W_LOAD,
        S_W_GAP,
        S_A_RD,
        S_EXEC,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam int INST_W     = 34;
    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP_HI    = 30;
    localparam int B_AP_LO    = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_AX_HI    = 17;
    localparam int B_AX_LO    = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_IFIFO_WR = 5;
    localparam int B_IFIFO_RD = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // Both SRAMs deselected, every other field low.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    localparam int ST_OFIFO_VALID = 4;
    localparam int ST_OFIFO_READY = 3;
    localparam int ST_OFIFO_FULL  = 2;
    localparam int ST_L0_FULL     = 1;
    localparam int ST_L0_READY    = 0;

endpackage

// File: rtl/core_seq_rd_issuer.sv
// rtl/core_seq_rd_issuer.sv - stall-aware xmem read issuer with one-cycle-delayed l0_wr
module seq_rd_issuer #(
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    input  logic               i_stall,
    input  logic [addr_bw-1:0] i_base,
    input  logic [addr_bw-1:0] i_len,
    output logic               o_issue,
    output logic               o_last,
    output logic [addr_bw-1:0] o_addr,
    output logic               o_l0_wr
);

    localparam logic [addr_bw-1:0] ONE = addr_bw'(1);

    logic [addr_bw-1:0] r_cnt;
    logic               r_l0_wr;

    assign o_issue = i_en && !i_stall;
    assign o_last  = o_issue && (r_cnt == i_len - ONE);
    assign o_addr  = i_base + r_cnt;
    assign o_l0_wr = r_l0_wr;

    // Counter self-clears on the final read so the next burst starts at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_l0_wr <= 1'b0;
        end else begin
            r_l0_wr <= o_issue;
            if (o_issue) r_cnt <= o_last ? '0 : r_cnt + ONE;
        end
    end

endmodule

// File: rtl/core_seq.sv
// rtl/core_seq.sv - weight-stationary tile sequencer driving the core inst bus
module core_seq
    import core_pkg::*;
#(
    parameter int col      = 8,
    parameter int row      = 8,
    parameter int addr_bw  = 11,
    parameter int l0_depth = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] a_base,
    input  logic [addr_bw-1:0] a_len,
    input  logic [addr_bw-1:0] p_base,
    input  logic [4:0]         l0_ofifo_valid,
    output logic [33:0]        inst,
    output logic               busy,
    output logic               done
);

    localparam int G_W = (row > 1) ? $clog2(row) : 1;
    localparam logic [addr_bw-1:0] ONE     = addr_bw'(1);
    localparam logic [addr_bw-1:0] COL_LEN = addr_bw'(col);
    localparam logic [addr_bw-1:0] COL_M1  = addr_bw'(col - 1);
    localparam logic [G_W-1:0]     ROW_M1  = G_W'(row - 1);
    localparam logic [G_W-1:0]     G_ONE   = G_W'(1);
    localparam logic [addr_bw:0]   L0_CAP  = (addr_bw + 1)'(l0_depth);

    state_t             r_state, w_next;
    logic [addr_bw-1:0] r_w_base, r_a_base, r_a_len, r_p_base;
    logic [addr_bw-1:0] r_lcnt, r_rcnt, r_pcnt;
    logic [G_W-1:0]     r_gcnt;
    logic               r_pend;
    logic [33:0]        r_inst, w_inst;

    logic               w_rd_en, w_issue, w_rd_last, w_l0_wr;
    logic [addr_bw-1:0] w_rd_base, w_rd_len, w_rd_addr;
    logic               w_load_end, w_exec_end, w_gap_end;
    logic               w_ofrd, w_pw, w_drain_end;
    logic               w_unused;

    assign w_unused = ^{l0_ofifo_valid[ST_OFIFO_READY], l0_ofifo_valid[ST_OFIFO_FULL],
                        l0_ofifo_valid[ST_L0_READY], L0_CAP};

    assign w_rd_en   = (r_state == S_W_RD) || (r_state == S_A_RD);
    assign w_rd_base = (r_state == S_A_RD) ? r_a_base : r_w_base;
    assign w_rd_len  = (r_state == S_A_RD) ? r_a_len  : COL_LEN;

    seq_rd_issuer #(.addr_bw(addr_bw)) u_rd_issuer (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_rd_en),
        .i_stall (l0_ofifo_valid[ST_L0_FULL]),
        .i_base  (w_rd_base),
        .i_len   (w_rd_len),
        .o_issue (w_issue),
        .o_last  (w_rd_last),
        .o_addr  (w_rd_addr),
        .o_l0_wr (w_l0_wr)
    );

    assign w_load_end  = (r_state == S_W_LOAD) && (r_lcnt == COL_M1);
    assign w_exec_end  = (r_state == S_EXEC) && (r_lcnt == r_a_len - ONE);
    assign w_gap_end   = (r_state == S_W_GAP) && (r_gcnt == ROW_M1);
    // r_pend marks an ofifo pop from the previous cycle whose data is written now.
    assign w_ofrd      = (r_state == S_DRAIN) && l0_ofifo_valid[ST_OFIFO_VALID] && (r_rcnt != r_a_len);
    assign w_pw        = (r_state == S_DRAIN) && r_pend;
    assign w_drain_end = w_pw && (r_pcnt == r_a_len - ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_W_RD;
            S_W_RD:   if (w_rd_last) w_next = S_W_LOAD;
            S_W_LOAD: if (w_load_end) w_next = S_W_GAP;
            S_W_GAP:  if (w_gap_end) w_next = (r_a_len == '0) ? S_FIN : S_A_RD;
            S_A_RD:   if (w_rd_last) w_next = S_EXEC;
            S_EXEC:   if (w_exec_end) w_next = S_DRAIN;
            S_DRAIN:  if (w_drain_end) w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w_base <= '0;
            r_a_base <= '0;
            r_a_len  <= '0;
            r_p_base <= '0;
            r_lcnt   <= '0;
            r_gcnt   <= '0;
            r_rcnt   <= '0;
            r_pcnt   <= '0;
            r_pend   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_w_base <= w_base;
                r_a_base <= a_base;
                r_a_len  <= a_len;
                r_p_base <= p_base;
            end
            if ((r_state == S_W_LOAD) || (r_state == S_EXEC))
                r_lcnt <= (w_load_end || w_exec_end) ? '0 : r_lcnt + ONE;
            if (r_state == S_W_GAP)
                r_gcnt <= w_gap_end ? '0 : r_gcnt + G_ONE;
            r_pend <= w_ofrd;
            if (r_state == S_FIN) begin
                r_rcnt <= '0;
                r_pcnt <= '0;
            end else begin
                if (w_ofrd) r_rcnt <= r_rcnt + ONE;
                if (w_pw)   r_pcnt <= r_pcnt + ONE;
            end
        end
    end

    always_comb begin
        w_inst          = INST_IDLE;
        w_inst[B_L0_WR] = w_l0_wr;
        case (r_state)
            S_W_RD, S_A_RD: begin
                w_inst[B_CEN_X]         = !w_issue;
                w_inst[B_AX_HI:B_AX_LO] = w_rd_addr;
            end
            S_W_LOAD: begin
                w_inst[B_L0_RD] = 1'b1;
                w_inst[B_LOAD]  = 1'b1;
            end
            S_EXEC: begin
                w_inst[B_L0_RD] = 1'b1;
                w_inst[B_EXEC]  = 1'b1;
            end
            S_DRAIN: begin
                w_inst[B_OFIFO_RD] = w_ofrd;
                if (w_pw) begin
                    w_inst[B_CEN_P]         = 1'b0;
                    w_inst[B_WEN_P]         = 1'b0;
                    w_inst[B_AP_HI:B_AP_LO] = r_p_base + r_pcnt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_inst <= INST_IDLE;
        else        r_inst <= w_inst;
    end

    assign inst = r_inst;
    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_FIN);

endmodule

// File: tb/tb_core_seq.sv
// tb/tb_core_seq.sv - scoreboard bench for core_seq with randomized tiles and status stalls
module tb_core_seq;

    logic        clk, reset, start;
    logic [10:0] w_base, a_base, a_len, p_base;
    logic [4:0]  st;
    logic [33:0] inst;
    logic        busy, done;

    core_seq dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .w_base         (w_base),
        .a_base         (a_base),
        .a_len          (a_len),
        .p_base         (p_base),
        .l0_ofifo_valid (st),
        .inst           (inst),
        .busy           (busy),
        .done           (done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int checks = 0, errors = 0;
    logic [10:0] q_x[$];
    logic [10:0] q_p[$];

    int vmode = 0, smode = 0;
    bit force_full = 0;
    logic v_edge = 0;
    int cyc = 0;

    int n_rd, n_l0wr, n_load, n_exec, n_ofrd, n_pw, n_done;
    int rd_w_first, rd_w_last, rd_a_first, rd_a_last;
    int load_first, load_last, exec_first, exec_last;
    int ofrd_first, ofrd_last, pw_first, pw_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        n_rd = 0; n_l0wr = 0; n_load = 0; n_exec = 0; n_ofrd = 0; n_pw = 0; n_done = 0;
        rd_w_first = -1; rd_w_last = -1; rd_a_first = -1; rd_a_last = -1;
        load_first = -1; load_last = -1; exec_first = -1; exec_last = -1;
        ofrd_first = -1; ofrd_last = -1; pw_first = -1; pw_last = -1;
    endtask

    always @(posedge clk) v_edge <= st[4];

    // Status driver: ofifo valid pattern, l0 full stalls, irrelevant bits random.
    initial begin
        st = '0;
        forever begin
            @(negedge clk); #1;
            st[4] = (vmode == 1) ? 1'b1 : ($urandom_range(0, 2) == 0);
            st[1] = force_full | ((smode != 0) && ($urandom_range(0, 3) == 0));
            st[3] = 1'($urandom);
            st[2] = 1'($urandom);
            st[0] = 1'($urandom);
        end
    end

    // Monitor: pops the scoreboard whenever the bus shows a read or a write.
    initial begin
        bit rd, ofrd, pw, prev_rd, prev_ofrd;
        prev_rd = 0; prev_ofrd = 0;
        clear_stats();
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                prev_rd = 0;
                prev_ofrd = 0;
            end else begin
                rd   = !inst[19];
                ofrd = inst[6];
                pw   = !inst[32];
                chk("held_zero", {61'd0, inst[33], inst[5], inst[4]}, 0);
                chk("wen_xmem", inst[18], 1);
                chk("wen_pmem", inst[31], inst[32]);
                chk("l0_wr", inst[2], prev_rd);
                chk("l0_rd", inst[3], inst[0] | inst[1]);
                if (inst[2]) n_l0wr++;
                if (rd) begin
                    if (q_x.size() == 0) chk("xaddr_unexpected", 1, 0);
                    else chk("xaddr", inst[17:7], q_x.pop_front());
                    if (n_rd < 8) begin
                        if (n_rd == 0) rd_w_first = cyc;
                        rd_w_last = cyc;
                    end else begin
                        if (n_rd == 8) rd_a_first = cyc;
                        rd_a_last = cyc;
                    end
                    n_rd++;
                end
                if (inst[0]) begin
                    if (n_load == 0) load_first = cyc;
                    load_last = cyc;
                    n_load++;
                end
                if (inst[1]) begin
                    if (n_exec == 0) exec_first = cyc;
                    exec_last = cyc;
                    n_exec++;
                end
                if (ofrd) begin
                    chk("ofrd_needs_valid", v_edge, 1);
                    if (n_ofrd == 0) ofrd_first = cyc;
                    ofrd_last = cyc;
                    n_ofrd++;
                end
                if (pw) begin
                    chk("pw_after_ofrd", prev_ofrd, 1);
                    if (q_p.size() == 0) chk("paddr_unexpected", 1, 0);
                    else chk("paddr", inst[30:20], q_p.pop_front());
                    if (n_pw == 0) pw_first = cyc;
                    pw_last = cyc;
                    n_pw++;
                end
                if (done) n_done++;
                prev_rd = rd;
                prev_ofrd = ofrd;
            end
        end
    end

    task automatic push_model(input logic [10:0] wb, input logic [10:0] ab,
                              input logic [10:0] al, input logic [10:0] pb);
        for (int i = 0; i < 8; i++) q_x.push_back(wb + 11'(i));
        for (int i = 0; i < int'(al); i++) q_x.push_back(ab + 11'(i));
        for (int i = 0; i < int'(al); i++) q_p.push_back(pb + 11'(i));
    endtask

    task automatic run_tile(input logic [10:0] wb, input logic [10:0] ab, input logic [10:0] al,
                            input logic [10:0] pb, input int vm, input int sm, input bit wstall);
        bit got;
        int alen;
        alen = int'(al);
        clear_stats();
        push_model(wb, ab, al, pb);
        vmode = vm;
        smode = sm;
        @(negedge clk); #2;
        w_base = wb; a_base = ab; a_len = al; p_base = pb; start = 1;
        @(negedge clk); #2;
        start = 0;
        w_base = 11'($urandom); a_base = 11'($urandom);
        a_len = 11'($urandom_range(0, 64)); p_base = 11'($urandom);
        if (wstall) begin
            got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk); #2;
                if (n_rd == 2) got = 1;
            end
            chk("stall_arm", got, 1);
            force_full = 1;
            repeat (3) @(negedge clk);
            #2 force_full = 0;
        end
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk); #2;
            start = (i == 5);
            if (n_done != 0) got = 1;
        end
        start = 0;
        chk("done_seen", got, 1);
        repeat (3) @(negedge clk);
        #2;
        chk("q_x_empty", q_x.size(), 0);
        chk("q_p_empty", q_p.size(), 0);
        chk("n_rd", n_rd, 8 + alen);
        chk("n_l0wr", n_l0wr, 8 + alen);
        chk("n_load", n_load, 8);
        chk("load_span", load_last - load_first, 7);
        chk("load_after_wrd", load_first, rd_w_last + 1);
        chk("n_exec", n_exec, alen);
        chk("n_ofrd", n_ofrd, alen);
        chk("n_pw", n_pw, alen);
        chk("n_done", n_done, 1);
        chk("busy_end", busy, 0);
        chk("inst_end", inst, 34'h1_800C_0000);
        if (sm == 0) chk("w_rd_span", rd_w_last - rd_w_first, wstall ? 10 : 7);
        if (alen > 0) begin
            chk("exec_span", exec_last - exec_first, alen - 1);
            chk("exec_after_ard", exec_first > rd_a_last, 1);
            if (sm == 0) chk("gap_len", rd_a_first - load_last - 1, 8);
        end
        if (vm == 1 && alen > 0) begin
            chk("b2b_ofrd_span", ofrd_last - ofrd_first, alen - 1);
            chk("b2b_pw_offset", pw_first, ofrd_first + 1);
            chk("b2b_pw_span", pw_last - pw_first, alen - 1);
        end
    endtask

    initial begin
        bit got;
        reset = 0; start = 0;
        w_base = 0; a_base = 0; a_len = 0; p_base = 0;
        repeat (2) @(negedge clk);
        #2 start = 1;
        @(negedge clk); #2 start = 0;
        chk("rst_inst", inst, 34'h1_800C_0000);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk); #2 reset = 1;
        repeat (3) @(negedge clk);
        #2;
        chk("idle_inst", inst, 34'h1_800C_0000);
        chk("idle_busy", busy, 0);

        run_tile(11'd0, 11'd16, 11'd4, 11'd100, 0, 0, 0);
        run_tile(11'd0, 11'd16, 11'd4, 11'd100, 0, 0, 1);
        run_tile(11'd0, 11'd16, 11'd4, 11'd100, 1, 0, 0);
        run_tile(11'd32, 11'd48, 11'd0, 11'd200, 1, 0, 0);
        run_tile(11'h7FC, 11'h7FE, 11'd5, 11'h7FD, 1, 0, 0);

        // Abort a tile during EXEC and confirm a clean restart.
        clear_stats();
        push_model(11'd5, 11'd40, 11'd8, 11'd7);
        vmode = 0; smode = 0;
        @(negedge clk); #2;
        w_base = 11'd5; a_base = 11'd40; a_len = 11'd8; p_base = 11'd7; start = 1;
        @(negedge clk); #2 start = 0;
        got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk); #2;
            if (n_exec >= 2) got = 1;
        end
        chk("exec_reached", got, 1);
        reset = 0;
        @(posedge clk); #1;
        chk("abort_inst", inst, 34'h1_800C_0000);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) @(negedge clk);
        q_x.delete();
        q_p.delete();
        #2 reset = 1;
        repeat (5) @(negedge clk);
        #2;
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", busy, 0);
        run_tile(11'd9, 11'd60, 11'd6, 11'd300, 0, 0, 0);

        for (int t = 0; t < 6; t++) begin
            run_tile(11'($urandom), 11'($urandom), 11'($urandom_range(0, 12)), 11'($urandom),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
